// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port SRAM between an instruction-fetch requester (m0)
//   and an LSU requester (m1). The LSU has fixed priority. A saturating stall
//   counter makes m0 win the next conflict after MAX_STALL consecutive losses.
//   Read data returns exactly one cycle after the grant.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   mN_req_i/gnt_o/rvalid_o  req/gnt/rvalid handshake of requester N (0 = fetch, 1 = LSU)
//   mN_addr_i                byte address (word address taken from [MEM_ADDR_WIDTH+1:2])
//   mN_we_i/be_i/wdata_i     write enable, byte enables, write data
//   mN_rdata_o               read data, valid while mN_rvalid_o is high (0 otherwise)
//   mem_*                    SRAM macro interface (read data registered inside the macro)
//
// Optional build macro MEM_PORT_ARB_PERF_EN adds:
//   perf_clr_i               synchronous clear of both counters
//   perf_conflict_o          saturating count of cycles with both requests active
//   perf_forced_o            saturating count of m0 wins caused by starvation
module mem_port_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_STALL      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
`ifdef MEM_PORT_ARB_PERF_EN
  input  logic                      perf_clr_i,
  output logic [15:0]               perf_conflict_o,
  output logic [15:0]               perf_forced_o,
`endif
  input  logic                      m0_req_i,
  output logic                      m0_gnt_o,
  output logic                      m0_rvalid_o,
  input  logic [31:0]               m0_addr_i,
  input  logic                      m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,
  input  logic                      m1_req_i,
  output logic                      m1_gnt_o,
  output logic                      m1_rvalid_o,
  input  logic [31:0]               m1_addr_i,
  input  logic                      m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,
  output logic                      mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam logic [7:0] STALL_MAX = 8'(MAX_STALL);

  logic [7:0] stall_cnt_q;
  logic       rsp_valid_q;
  logic       rsp_sel_q;
  logic       starved;
  logic       unused_addr_bits;

  assign starved = (stall_cnt_q == STALL_MAX);

  // Only the word-address slice of each byte address reaches the SRAM.
  assign unused_addr_bits = ^{m0_addr_i[31:MEM_ADDR_WIDTH+2], m0_addr_i[1:0],
                              m1_addr_i[31:MEM_ADDR_WIDTH+2], m1_addr_i[1:0]};

  // Grants are combinational; gated by rst_ni so nothing reaches the SRAM in reset.
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (rst_ni) begin
      if (m0_req_i && (!m1_req_i || starved)) begin
        m0_gnt_o = 1'b1;
      end else if (m1_req_i) begin
        m1_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o   = m0_gnt_o | m1_gnt_o;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (m0_gnt_o) begin
      mem_addr_o  = m0_addr_i[MEM_ADDR_WIDTH+1:2];
      mem_we_o    = m0_we_i;
      mem_be_o    = m0_be_i;
      mem_wdata_o = m0_wdata_i;
    end else if (m1_gnt_o) begin
      mem_addr_o  = m1_addr_i[MEM_ADDR_WIDTH+1:2];
      mem_we_o    = m1_we_i;
      mem_be_o    = m1_be_i;
      mem_wdata_o = m1_wdata_i;
    end
  end

  // Counts consecutive lost conflicts of m0; any m0 grant or idle m0 clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (!m0_req_i || m0_gnt_o) begin
      stall_cnt_q <= '0;
    end else if (m1_gnt_o && !starved) begin
      stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= 1'b0;
    end else begin
      rsp_valid_q <= mem_req_o;
      rsp_sel_q   <= m1_gnt_o;
    end
  end

  always_comb begin
    m0_rvalid_o = rsp_valid_q & ~rsp_sel_q;
    m1_rvalid_o = rsp_valid_q & rsp_sel_q;
    m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
  end

`ifdef MEM_PORT_ARB_PERF_EN
  logic conflict;
  assign conflict = m0_req_i & m1_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_conflict_o <= '0;
      perf_forced_o   <= '0;
    end else if (perf_clr_i) begin
      perf_conflict_o <= '0;
      perf_forced_o   <= '0;
    end else begin
      if (conflict && perf_conflict_o != '1) begin
        perf_conflict_o <= perf_conflict_o + 16'd1;
      end
      // In a conflict m0 only wins when starved.
      if (conflict && starved && perf_forced_o != '1) begin
        perf_forced_o <= perf_forced_o + 16'd1;
      end
    end
  end
`endif

endmodule
